// File: rtl/riscv_pkg.sv
// Shared RV32 constants and the fetch FSM state type.
package riscv_pkg;

  localparam int unsigned XLEN = 32;

  // Canonical NOP: addi x0, x0, 0
  localparam logic [XLEN-1:0] NOP_INSTR = 32'h0000_0013;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OP_IMM = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StFetch = 2'd1,
    StFault = 2'd2
  } fetch_state_e;

endpackage

// File: rtl/ifid_reg.sv
// IF/ID pipeline register: load a fetched instruction, hold it, or flush it to a NOP bubble.
module ifid_reg #(
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        load,
  input  logic        flush,
  input  logic [31:0] pc_in,
  input  logic [31:0] instr_in,
  output logic        valid,
  output logic [31:0] pc,
  output logic [31:0] instr
);

  import riscv_pkg::*;

  logic             valid_q;
  logic [XLEN-1:0]  pc_q;
  logic [XLEN-1:0]  instr_q;

  // Flush beats load; neither asserted means hold.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (flush) begin
      valid_q <= 1'b0;
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
    end else if (load) begin
      valid_q <= 1'b1;
      pc_q    <= pc_in;
      instr_q <= instr_in;
    end
  end

  assign valid = valid_q;
  assign pc    = pc_q;
  assign instr = instr_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch stage: PC, fetch FSM and the IF/ID register.
module fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = riscv_pkg::NOP_INSTR
) (
  input  logic        clk,
  input  logic        rst_n,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ready,
  input  logic [31:0] imem_rdata,
  input  logic        stall_i,
  input  logic        branch_taken_i,
  input  logic [31:0] branch_target_i,
  output logic        ifid_valid,
  output logic [31:0] ifid_pc,
  output logic [31:0] ifid_instr,
  output logic [6:0]  ifid_opcode,
  output logic        fetch_fault
);

  import riscv_pkg::*;

  fetch_state_e    state_q;
  logic [XLEN-1:0] pc_q;
  logic            fault_q;

  logic            stall_hold;
  logic            ifid_load;
  logic            ifid_flush;

  // A stall only counts when decode actually holds something; a bubble never blocks.
  always_comb begin
    stall_hold = stall_i && ifid_valid;
    imem_req   = (state_q == StFetch) && !stall_hold;
  end

  // IF/ID control: redirect flushes, stall holds, ready loads, otherwise insert a bubble.
  always_comb begin
    ifid_load  = 1'b0;
    ifid_flush = 1'b0;
    unique case (state_q)
      StFetch: begin
        if (branch_taken_i) begin
          ifid_flush = 1'b1;
        end else if (stall_hold) begin
          ifid_load = 1'b0;
        end else if (imem_ready) begin
          ifid_load = 1'b1;
        end else begin
          ifid_flush = 1'b1;
        end
      end
      StFault: ifid_flush = 1'b1;
      default: ifid_load  = 1'b0;
    endcase
  end

  // Fetch FSM with PC and sticky fault flag; FAULT is left only through reset.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StIdle;
      pc_q    <= RESET_PC;
      fault_q <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: state_q <= StFetch;
        StFetch: begin
          if (branch_taken_i) begin
            if (branch_target_i[1:0] != 2'b00) begin
              // Misaligned redirect: keep the last legal PC and park.
              state_q <= StFault;
              fault_q <= 1'b1;
            end else begin
              pc_q <= branch_target_i;
            end
          end else if (!stall_hold && imem_ready) begin
            pc_q <= pc_q + 32'd4;
          end
        end
        StFault: fault_q <= 1'b1;
        default: state_q <= StIdle;
      endcase
    end
  end

  ifid_reg #(
    .NOP_INSTR (NOP_INSTR)
  ) u_ifid_reg (
    .clk      (clk),
    .rst_n    (rst_n),
    .load     (ifid_load),
    .flush    (ifid_flush),
    .pc_in    (pc_q),
    .instr_in (imem_rdata),
    .valid    (ifid_valid),
    .pc       (ifid_pc),
    .instr    (ifid_instr)
  );

  assign imem_addr   = pc_q;
  assign ifid_opcode = ifid_instr[6:0];
  assign fetch_fault = fault_q;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: sequencing, stall, flush, bubble, fault, wrap and async reset.
module tb_fetch_unit;

  logic        clk;
  logic        rst_n;
  logic        imem_ready;
  logic [31:0] imem_rdata;
  logic        stall_i;
  logic        branch_taken_i;
  logic [31:0] branch_target_i;

  logic        imem_req;
  logic [31:0] imem_addr;
  logic        ifid_valid;
  logic [31:0] ifid_pc;
  logic [31:0] ifid_instr;
  logic [6:0]  ifid_opcode;
  logic        fetch_fault;

  // Second instance with a wrapping reset PC.
  logic        d2_ready;
  logic [31:0] d2_rdata;
  logic        d2_req;
  logic [31:0] d2_addr;
  logic        d2_valid;
  logic [31:0] d2_pc;
  logic [31:0] d2_instr;
  logic [6:0]  d2_opcode;
  logic        d2_fault;

  int n_assert = 0;
  int n_fail   = 0;

  fetch_unit u_dut (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (imem_req),
    .imem_addr       (imem_addr),
    .imem_ready      (imem_ready),
    .imem_rdata      (imem_rdata),
    .stall_i         (stall_i),
    .branch_taken_i  (branch_taken_i),
    .branch_target_i (branch_target_i),
    .ifid_valid      (ifid_valid),
    .ifid_pc         (ifid_pc),
    .ifid_instr      (ifid_instr),
    .ifid_opcode     (ifid_opcode),
    .fetch_fault     (fetch_fault)
  );

  fetch_unit #(
    .RESET_PC (32'hFFFF_FFFC)
  ) u_dut2 (
    .clk             (clk),
    .rst_n           (rst_n),
    .imem_req        (d2_req),
    .imem_addr       (d2_addr),
    .imem_ready      (d2_ready),
    .imem_rdata      (d2_rdata),
    .stall_i         (1'b0),
    .branch_taken_i  (1'b0),
    .branch_target_i (32'h0),
    .ifid_valid      (d2_valid),
    .ifid_pc         (d2_pc),
    .ifid_instr      (d2_instr),
    .ifid_opcode     (d2_opcode),
    .fetch_fault     (d2_fault)
  );

  // Memory image: instruction word = {addr[23:0], 8'h33}, so opcode is always OP.
  assign imem_rdata = {imem_addr[23:0], 8'h33};
  assign d2_rdata   = {d2_addr[23:0], 8'h33};
  assign d2_ready   = 1'b1;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n           = 1'b0;
    imem_ready      = 1'b1;
    stall_i         = 1'b0;
    branch_taken_i  = 1'b0;
    branch_target_i = 32'h0;

    // Reset values while held in reset.
    #12;
    chk("rst_req",    {31'b0, imem_req},    32'd0);
    chk("rst_addr",   imem_addr,            32'h0);
    chk("rst_valid",  {31'b0, ifid_valid},  32'd0);
    chk("rst_pc",     ifid_pc,              32'h0);
    chk("rst_instr",  ifid_instr,           32'h0000_0013);
    chk("rst_opcode", {25'b0, ifid_opcode}, 32'h13);
    chk("rst_fault",  {31'b0, fetch_fault}, 32'd0);
    chk("rst_d2addr", d2_addr,              32'hFFFF_FFFC);

    // Release; first edge is spent in IDLE.
    rst_n = 1'b1;
    #1;
    chk("idle_req", {31'b0, imem_req}, 32'd0);
    tick();
    chk("first_req",  {31'b0, imem_req},   32'd1);
    chk("first_addr", imem_addr,           32'h0);
    chk("first_valid",{31'b0, ifid_valid}, 32'd0);
    chk("d2_first",   d2_addr,             32'hFFFF_FFFC);

    // Streaming fetch: 0,4,8,C.
    tick();
    chk("s0_addr",  imem_addr,            32'h4);
    chk("s0_pc",    ifid_pc,              32'h0);
    chk("s0_valid", {31'b0, ifid_valid},  32'd1);
    chk("s0_instr", ifid_instr,           32'h0000_0033);
    chk("s0_opc",   {25'b0, ifid_opcode}, 32'h33);
    chk("d2_wrap",  d2_addr,              32'h0);
    chk("d2_pc",    d2_pc,                32'hFFFF_FFFC);
    tick();
    chk("s1_addr",  imem_addr,  32'h8);
    chk("s1_pc",    ifid_pc,    32'h4);
    chk("s1_instr", ifid_instr, 32'h0000_0433);
    tick();
    chk("s2_addr",  imem_addr, 32'hC);
    chk("s2_pc",    ifid_pc,   32'h8);
    tick();
    chk("s3_addr",  imem_addr, 32'h10);
    chk("s3_pc",    ifid_pc,   32'hC);

    // Stall three cycles with a valid instruction held.
    stall_i = 1'b1;
    #1;
    chk("stall_req", {31'b0, imem_req}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      tick();
      chk("stall_req_h",   {31'b0, imem_req},   32'd0);
      chk("stall_addr_h",  imem_addr,           32'h10);
      chk("stall_pc_h",    ifid_pc,             32'hC);
      chk("stall_valid_h", {31'b0, ifid_valid}, 32'd1);
    end
    stall_i = 1'b0;
    #1;
    chk("resume_req", {31'b0, imem_req}, 32'd1);
    tick();
    chk("resume_pc",   ifid_pc,   32'h10);
    chk("resume_addr", imem_addr, 32'h14);

    // Branch with ready and stall asserted: flush wins.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h40;
    stall_i         = 1'b1;
    tick();
    chk("br_valid", {31'b0, ifid_valid}, 32'd0);
    chk("br_instr", ifid_instr,          32'h0000_0013);
    chk("br_pc",    ifid_pc,             32'h0);
    chk("br_addr",  imem_addr,           32'h40);
    branch_taken_i = 1'b0;
    #1;
    // Stall against an empty IF/ID is not a stall.
    chk("bub_nostall_req", {31'b0, imem_req}, 32'd1);
    tick();
    chk("post_br_pc",    ifid_pc,             32'h40);
    chk("post_br_valid", {31'b0, ifid_valid}, 32'd1);
    chk("post_br_addr",  imem_addr,           32'h44);
    chk("post_br_req",   {31'b0, imem_req},   32'd0);
    stall_i = 1'b0;

    // Memory not ready: bubble, PC holds.
    imem_ready = 1'b0;
    tick();
    chk("bub_valid", {31'b0, ifid_valid}, 32'd0);
    chk("bub_instr", ifid_instr,          32'h0000_0013);
    chk("bub_addr",  imem_addr,           32'h44);
    imem_ready = 1'b1;

    // Misaligned target: sticky fault, PC keeps last legal value.
    branch_taken_i  = 1'b1;
    branch_target_i = 32'h42;
    tick();
    branch_taken_i = 1'b0;
    chk("flt_fault", {31'b0, fetch_fault}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      tick();
      chk("flt_fault_h", {31'b0, fetch_fault}, 32'd1);
      chk("flt_req_h",   {31'b0, imem_req},    32'd0);
      chk("flt_addr_h",  imem_addr,            32'h44);
      chk("flt_valid_h", {31'b0, ifid_valid},  32'd0);
    end

    // Reset pulse clears the fault.
    rst_n = 1'b0;
    #2;
    chk("clr_fault", {31'b0, fetch_fault}, 32'd0);
    chk("clr_addr",  imem_addr,            32'h0);
    rst_n = 1'b1;
    tick();
    tick();
    tick();
    chk("pre_ar_req",  {31'b0, imem_req},   32'd1);
    chk("pre_ar_addr", imem_addr,           32'h8);
    chk("pre_ar_valid",{31'b0, ifid_valid}, 32'd1);

    // Mid-period asynchronous reset, no clock edge in between.
    #2;
    rst_n = 1'b0;
    #1;
    chk("ar_req",   {31'b0, imem_req},    32'd0);
    chk("ar_addr",  imem_addr,            32'h0);
    chk("ar_valid", {31'b0, ifid_valid},  32'd0);
    chk("ar_pc",    ifid_pc,              32'h0);
    chk("ar_instr", ifid_instr,           32'h0000_0013);
    chk("ar_fault", {31'b0, fetch_fault}, 32'd0);
    chk("ar_d2addr", d2_addr,             32'hFFFF_FFFC);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
